// File: rtl/fisq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fisq_pkg
// Purpose  : Shared types and helpers for the filter index sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fisq_pkg;

    localparam int c_R_WIDTH  = 4;
    localparam int c_S_WIDTH  = 6;
    localparam int c_P_WIDTH  = 5;
    localparam int c_Q_WIDTH  = 3;
    localparam int c_RR_WIDTH = 2;
    localparam int c_T_WIDTH  = 3;
    localparam int c_BL_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [c_R_WIDTH-1:0]  rows;
        logic [c_S_WIDTH-1:0]  cols;
        logic [c_P_WIDTH-1:0]  filt;
        logic [c_Q_WIDTH-1:0]  chan;
        logic [c_RR_WIDTH-1:0] crep;
        logic [c_T_WIDTH-1:0]  frep;
        logic [c_BL_WIDTH-1:0] blen;
    } cfg_t;

    // A zero extent would make every wrap comparison meaningless.
    function automatic logic [7:0] clamp1(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_index_sequencer_counter.sv
`default_nettype none
// ============================================================================
// Module   : nested_wrap_counter
// Purpose  : 3-digit mixed-radix counter (digit 0 fastest) with base snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module nested_wrap_counter #(
    parameter int W0 = 1,
    parameter int W1 = 1,
    parameter int W2 = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_inc,
    input  logic          i_restore,
    input  logic          i_snapshot,
    input  logic [W0-1:0] i_rad0,
    input  logic [W1-1:0] i_rad1,
    input  logic [W2-1:0] i_rad2,
    output logic [W0-1:0] o_d0,
    output logic [W1-1:0] o_d1,
    output logic [W2-1:0] o_d2,
    output logic          o_wrap
);

    logic [W0-1:0] r_d0, r_b0, w_n0;
    logic [W1-1:0] r_d1, r_b1, w_n1;
    logic [W2-1:0] r_d2, r_b2, w_n2;
    logic          w_m0, w_m1, w_m2;

    assign w_m0 = (r_d0 == i_rad0 - W0'(1));
    assign w_m1 = (r_d1 == i_rad1 - W1'(1));
    assign w_m2 = (r_d2 == i_rad2 - W2'(1));

    always_comb begin
        w_n0 = w_m0 ? '0 : r_d0 + W0'(1);
        w_n1 = r_d1;
        w_n2 = r_d2;
        if (w_m0) begin
            w_n1 = w_m1 ? '0 : r_d1 + W1'(1);
            if (w_m1) begin
                w_n2 = w_m2 ? '0 : r_d2 + W2'(1);
            end
        end
    end

    // Restore rewinds to the snapshot; a snapshot captures the post-increment value.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_d0 <= '0; r_d1 <= '0; r_d2 <= '0;
            r_b0 <= '0; r_b1 <= '0; r_b2 <= '0;
        end else if (i_restore) begin
            r_d0 <= r_b0; r_d1 <= r_b1; r_d2 <= r_b2;
        end else if (i_inc) begin
            r_d0 <= w_n0; r_d1 <= w_n1; r_d2 <= w_n2;
            if (i_snapshot) begin
                r_b0 <= w_n0; r_b1 <= w_n1; r_b2 <= w_n2;
            end
        end
    end

    assign o_d0   = r_d0;
    assign o_d1   = r_d1;
    assign o_d2   = r_d2;
    assign o_wrap = w_m0 & w_m1 & w_m2;

endmodule
`default_nettype wire

// File: rtl/filter_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : filter_index_sequencer
// Purpose  : Burst-wise inner (p,q,S) walk replayed over every outer (t,r,R).
// Revision : 1.0 - initial release
// ============================================================================
module filter_index_sequencer
    import fisq_pkg::*;
#(
    parameter int R_WIDTH  = c_R_WIDTH,
    parameter int S_WIDTH  = c_S_WIDTH,
    parameter int p_WIDTH  = c_P_WIDTH,
    parameter int q_WIDTH  = c_Q_WIDTH,
    parameter int r_WIDTH  = c_RR_WIDTH,
    parameter int t_WIDTH  = c_T_WIDTH,
    parameter int BL_WIDTH = c_BL_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [R_WIDTH-1:0]         R,
    input  logic [S_WIDTH-1:0]         S,
    input  logic [p_WIDTH-1:0]         p,
    input  logic [q_WIDTH-1:0]         q,
    input  logic [r_WIDTH-1:0]         r,
    input  logic [t_WIDTH-1:0]         t,
    input  logic [BL_WIDTH-1:0]        burst_len,
    output logic                       busy,
    output logic                       done,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_burst_last,
    output logic                       out_last,
    output logic [p_WIDTH+t_WIDTH-1:0] filter_index,
    output logic [q_WIDTH+r_WIDTH-1:0] channel_index,
    output logic [R_WIDTH-1:0]         row_index,
    output logic [S_WIDTH-1:0]         col_index
);

    localparam int c_FW = p_WIDTH + t_WIDTH;
    localparam int c_CW = q_WIDTH + r_WIDTH;

    state_t              r_state;
    cfg_t                r_cfg;
    logic [BL_WIDTH-1:0] r_beat;

    logic [p_WIDTH-1:0]  w_pc;
    logic [q_WIDTH-1:0]  w_qc;
    logic [S_WIDTH-1:0]  w_sc;
    logic [t_WIDTH-1:0]  w_tc;
    logic [r_WIDTH-1:0]  w_rc;
    logic [R_WIDTH-1:0]  w_Rc;
    logic                w_in_wrap, w_out_wrap;
    logic                w_xfer, w_pass_end, w_last, w_active;
    logic                w_clear, w_in_inc, w_in_snap, w_in_restore, w_out_inc;

    assign w_active   = (r_state != IDLE);
    assign w_xfer     = (r_state == EMIT) && out_ready;
    // A pass ends on the programmed beat count or early when the inner walk runs out.
    assign w_pass_end = (r_beat == r_cfg.blen - BL_WIDTH'(1)) || w_in_wrap;
    assign w_last     = w_in_wrap && w_out_wrap;

    assign w_clear      = abort || ((r_state == IDLE) && start) || (w_xfer && w_last);
    assign w_in_inc     = w_xfer && !w_last && (!w_pass_end || w_out_wrap);
    assign w_in_snap    = w_xfer && !w_last && w_pass_end && w_out_wrap;
    assign w_in_restore = w_xfer && !w_last && w_pass_end && !w_out_wrap;
    assign w_out_inc    = w_xfer && !w_last && w_pass_end;

    nested_wrap_counter #(.W0(p_WIDTH), .W1(q_WIDTH), .W2(S_WIDTH)) u_inner (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_clear),
        .i_inc      (w_in_inc),
        .i_restore  (w_in_restore),
        .i_snapshot (w_in_snap),
        .i_rad0     (r_cfg.filt),
        .i_rad1     (r_cfg.chan),
        .i_rad2     (r_cfg.cols),
        .o_d0       (w_pc),
        .o_d1       (w_qc),
        .o_d2       (w_sc),
        .o_wrap     (w_in_wrap)
    );

    nested_wrap_counter #(.W0(t_WIDTH), .W1(r_WIDTH), .W2(R_WIDTH)) u_outer (
        .clk        (clk),
        .rst        (reset),
        .i_clear    (w_clear),
        .i_inc      (w_out_inc),
        .i_restore  (1'b0),
        .i_snapshot (1'b0),
        .i_rad0     (r_cfg.frep),
        .i_rad1     (r_cfg.crep),
        .i_rad2     (r_cfg.rows),
        .o_d0       (w_tc),
        .o_d1       (w_rc),
        .o_d2       (w_Rc),
        .o_wrap     (w_out_wrap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cfg   <= '0;
            r_beat  <= '0;
        end else if (abort) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cfg.rows <= c_R_WIDTH'(clamp1(8'(R)));
                        r_cfg.cols <= c_S_WIDTH'(clamp1(8'(S)));
                        r_cfg.filt <= c_P_WIDTH'(clamp1(8'(p)));
                        r_cfg.chan <= c_Q_WIDTH'(clamp1(8'(q)));
                        r_cfg.crep <= c_RR_WIDTH'(clamp1(8'(r)));
                        r_cfg.frep <= c_T_WIDTH'(clamp1(8'(t)));
                        r_cfg.blen <= c_BL_WIDTH'(clamp1(8'(burst_len)));
                        r_beat     <= '0;
                        r_state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_beat  <= '0;
                        end else if (w_pass_end) begin
                            r_beat <= '0;
                        end else begin
                            r_beat <= r_beat + BL_WIDTH'(1);
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_valid      = (r_state == EMIT);
    assign busy           = w_active;
    assign done           = (r_state == DONE);
    assign out_burst_last = out_valid && w_pass_end;
    assign out_last       = out_valid && w_last;

    assign filter_index  = w_active ? (c_FW'(w_pc) + c_FW'(w_tc) * c_FW'(r_cfg.filt)) : '0;
    assign channel_index = w_active ? (c_CW'(w_qc) + c_CW'(w_rc) * c_CW'(r_cfg.chan)) : '0;
    assign row_index     = w_active ? w_Rc : '0;
    assign col_index     = w_active ? w_sc : '0;

endmodule
`default_nettype wire

// File: tb/tb_filter_index_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_filter_index_sequencer
// Purpose  : Directed self-checking bench for filter_index_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_filter_index_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, abort, out_ready;
    logic [3:0] cfg_R;
    logic [5:0] cfg_S;
    logic [4:0] cfg_p;
    logic [2:0] cfg_q;
    logic [1:0] cfg_r;
    logic [2:0] cfg_t;
    logic [3:0] cfg_bl;
    logic       busy, done, out_valid, out_burst_last, out_last;
    logic [7:0] filter_index;
    logic [4:0] channel_index;
    logic [3:0] row_index;
    logic [5:0] col_index;

    int n_cmp = 0;
    int n_err = 0;

    int   cap_f[64], cap_c[64], cap_row[64], cap_col[64];
    logic cap_bl[64], cap_l[64];
    int   n_beats, stall_err, first_cyc;
    logic timed_out, done1, v1, done2, busy2;

    always #5 clk = ~clk;

    filter_index_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .R              (cfg_R),
        .S              (cfg_S),
        .p              (cfg_p),
        .q              (cfg_q),
        .r              (cfg_r),
        .t              (cfg_t),
        .burst_len      (cfg_bl),
        .busy           (busy),
        .done           (done),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_burst_last (out_burst_last),
        .out_last       (out_last),
        .filter_index   (filter_index),
        .channel_index  (channel_index),
        .row_index      (row_index),
        .col_index      (col_index)
    );

    task automatic set_cfg(input int pp, qq, ss, bl, tt, rr, rw);
        cfg_p = 5'(pp); cfg_q = 3'(qq); cfg_S = 6'(ss); cfg_bl = 4'(bl);
        cfg_t = 3'(tt); cfg_r = 2'(rr); cfg_R = 4'(rw);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records accepted beats; ready_mode 1 drives the 1,0,0 repeating pattern.
    task automatic capture(input int budget, input int ready_mode, input int inj_at);
        logic        stalled;
        logic [26:0] snap, cur;
        n_beats = 0; stall_err = 0; timed_out = 1'b1; stalled = 1'b0; first_cyc = -1;
        done1 = 1'b0; v1 = 1'b1; done2 = 1'b1; busy2 = 1'b1; snap = '0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            out_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            start = (inj_at >= 0) && (n_beats == inj_at);
            if (start) cfg_p = 5'd3;
            #1;
            cur = {out_valid, out_burst_last, out_last, filter_index, channel_index,
                   row_index, col_index};
            if (stalled && cur !== snap) stall_err++;
            stalled = out_valid && !out_ready;
            snap = cur;
            if (out_valid && out_ready && n_beats < 64) begin
                if (first_cyc < 0) first_cyc = cyc;
                cap_f[n_beats]   = int'(filter_index);
                cap_c[n_beats]   = int'(channel_index);
                cap_row[n_beats] = int'(row_index);
                cap_col[n_beats] = int'(col_index);
                cap_bl[n_beats]  = out_burst_last;
                cap_l[n_beats]   = out_last;
                n_beats++;
                if (out_last) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (!timed_out) begin
            @(negedge clk); #1 done1 = done; v1 = out_valid;
            @(negedge clk); #1 done2 = done; busy2 = busy;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({busy, done, out_valid, out_burst_last, out_last, filter_index, channel_index,
             row_index, col_index} !== 28'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b f=%0d c=%0d expected all 0",
                     busy, done, out_valid, filter_index, channel_index);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_basic_seq(input string tag);
        int   exp_f[12] = '{0, 1, 0, 1, 2, 3, 2, 3, 0, 1, 2, 3};
        int   exp_c[12] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 2, 2};
        logic [11:0] exp_bl = 12'hA88;
        n_cmp++;
        if (timed_out !== 1'b0 || n_beats != 12) begin
            n_err++;
            $display("FAIL %s_count: got %0d beats (timeout=%b) expected 12", tag, n_beats, timed_out);
        end
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (cap_f[i] != exp_f[i] || cap_col[i] != exp_c[i] || cap_bl[i] !== exp_bl[i] ||
                cap_l[i] !== (i == 11) || cap_c[i] != 0 || cap_row[i] != 0) begin
                n_err++;
                $display("FAIL %s_beat%0d: got f=%0d col=%0d bl=%b l=%b expected f=%0d col=%0d bl=%b l=%b",
                         tag, i, cap_f[i], cap_col[i], cap_bl[i], cap_l[i], exp_f[i], exp_c[i],
                         exp_bl[i], (i == 11));
            end
        end
        n_cmp++;
        if (done1 !== 1'b1 || v1 !== 1'b0 || done2 !== 1'b0 || busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done: got done=%b valid=%b then done=%b busy=%b expected 1 0 0 0",
                     tag, done1, v1, done2, busy2);
        end
    endtask

    task automatic test_basic();
        set_cfg(2, 1, 3, 4, 2, 1, 1);
        do_start();
        capture(100, 0, -1);
        n_cmp++;
        if (first_cyc != 0) begin
            n_err++;
            $display("FAIL basic_latency: got first beat at cycle %0d expected 0", first_cyc);
        end
        check_basic_seq("basic");
    endtask

    task automatic test_backpressure();
        set_cfg(2, 1, 3, 4, 2, 1, 1);
        do_start();
        capture(200, 1, -1);
        n_cmp++;
        if (stall_err != 0) begin
            n_err++;
            $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_err);
        end
        check_basic_seq("bp");
    endtask

    task automatic test_outer_nest();
        int exp_c[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        set_cfg(1, 2, 1, 2, 1, 2, 2);
        do_start();
        capture(100, 0, -1);
        n_cmp++;
        if (timed_out !== 1'b0 || n_beats != 8) begin
            n_err++;
            $display("FAIL outer_count: got %0d beats expected 8", n_beats);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (cap_c[i] != exp_c[i] || cap_row[i] != i / 4 || cap_f[i] != 0 || cap_col[i] != 0 ||
                cap_bl[i] !== i[0] || cap_l[i] !== (i == 7)) begin
                n_err++;
                $display("FAIL outer_beat%0d: got ch=%0d row=%0d bl=%b l=%b expected ch=%0d row=%0d bl=%b l=%b",
                         i, cap_c[i], cap_row[i], cap_bl[i], cap_l[i], exp_c[i], i / 4, i[0], (i == 7));
            end
        end
    endtask

    task automatic test_corners();
        set_cfg(3, 1, 1, 0, 1, 1, 1);
        do_start();
        capture(50, 0, -1);
        n_cmp++;
        if (n_beats != 3 || timed_out !== 1'b0) begin
            n_err++;
            $display("FAIL bl0_count: got %0d beats expected 3", n_beats);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cap_f[i] != i || cap_bl[i] !== 1'b1 || cap_l[i] !== (i == 2)) begin
                n_err++;
                $display("FAIL bl0_beat%0d: got f=%0d bl=%b l=%b expected f=%0d bl=1 l=%b",
                         i, cap_f[i], cap_bl[i], cap_l[i], i, (i == 2));
            end
        end
        set_cfg(3, 1, 1, 15, 1, 1, 1);
        do_start();
        capture(50, 0, -1);
        n_cmp++;
        if (n_beats != 3 || timed_out !== 1'b0) begin
            n_err++;
            $display("FAIL bl15_count: got %0d beats expected 3", n_beats);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cap_f[i] != i || cap_bl[i] !== (i == 2) || cap_l[i] !== (i == 2)) begin
                n_err++;
                $display("FAIL bl15_beat%0d: got f=%0d bl=%b l=%b expected f=%0d bl=%b l=%b",
                         i, cap_f[i], cap_bl[i], cap_l[i], i, (i == 2), (i == 2));
            end
        end
    endtask

    task automatic test_abort();
        logic saw_done;
        set_cfg(2, 1, 3, 4, 2, 1, 1);
        out_ready = 1'b1;
        do_start();
        repeat (5) @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || filter_index != 8'd3 || col_index != 6'd0) begin
            n_err++;
            $display("FAIL abort_beat5: got valid=%b f=%0d col=%0d expected 1 3 0",
                     out_valid, filter_index, col_index);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got valid=%b busy=%b done=%b expected 0 0 0",
                     out_valid, busy, done);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 if (done) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_nodone: got done pulse=%b expected 0", saw_done);
        end
        do_start();
        capture(100, 0, -1);
        check_basic_seq("replay");
    endtask

    task automatic test_control();
        set_cfg(2, 1, 3, 4, 2, 1, 1);
        do_start();
        capture(100, 0, 3);
        check_basic_seq("emitstart");
        set_cfg(2, 1, 3, 4, 2, 1, 1);
        do_start();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_pre_valid: got %b expected 1", out_valid);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++;
        if ({busy, done, out_valid, out_burst_last, out_last, filter_index, channel_index,
             row_index, col_index} !== 28'd0) begin
            n_err++;
            $display("FAIL rst_mid: got valid=%b busy=%b f=%0d col=%0d expected all 0",
                     out_valid, busy, filter_index, col_index);
        end
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort: got busy=%b valid=%b expected 0 0", busy, out_valid);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL start_abort_hold: got busy=%b valid=%b done=%b expected 0 0 0",
                     busy, out_valid, done);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_basic();
        test_backpressure();
        test_outer_nest();
        test_corners();
        test_abort();
        test_control();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/filter_index_sequencer.md
Name: filter_index_sequencer

Overview:
- Successor filter-index generator for the NoC controller.
- Walks an inner (p, q, S) window in bursts of runtime-programmable length and replays each burst over every outer (t, r, R) combination.
- Emits filter/channel/row/column index tuples over a valid/ready interface, with no bubble cycles between bursts.
- Adds over the previous generation: runtime burst length, a truncated final burst (no frozen padding beats), per-burst and end-of-sequence markers, and abort.

Parameters:
R_WIDTH, 4, width of R and row_index
S_WIDTH, 6, width of S and col_index
p_WIDTH, 5, width of p
q_WIDTH, 3, width of q
r_WIDTH, 2, width of r
t_WIDTH, 3, width of t
BL_WIDTH, 4, width of burst_len

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  begin sequence; accepted only in IDLE
abort  in  1  synchronous cancel
R  in  R_WIDTH  filter rows
S  in  S_WIDTH  columns
p  in  p_WIDTH  filters per PE set
q  in  q_WIDTH  channels per PE set
r  in  r_WIDTH  channel-group replication
t  in  t_WIDTH  filter-group replication
burst_len  in  BL_WIDTH  inner beats per burst
busy  out  1  sequence in progress
done  out  1  one-cycle completion pulse
out_valid  out  1  index tuple valid
out_ready  in  1  consumer accepts tuple
out_burst_last  out  1  last beat of the current burst pass
out_last  out  1  final beat of the whole sequence
filter_index  out  p_WIDTH+t_WIDTH  p_c + t_c*p
channel_index  out  q_WIDTH+r_WIDTH  q_c + r_c*q
row_index  out  R_WIDTH  R_c
col_index  out  S_WIDTH  S_c

Behaviour:
- Reset: state IDLE; all counters 0; every output 0.
- Config latch: all config inputs are latched on accepted start. A value of 0 is clamped to 1. Inputs are ignored afterwards.
- States: IDLE, EMIT, DONE.
- IDLE:
  - start=1 -> latch config, zero all counters, go to EMIT.
  - The first out_valid appears in the cycle after start.
  - start is ignored in EMIT and DONE.
- Inner walk: linear position e over (S_c, q_c, p_c), p fastest, then q, then S. N = p*q*S.
- Burst structure:
  - Burst k covers e = base .. base+L-1, where L = min(burst_len, N-base).
  - For each burst, the outer loop runs R_c from 0 to R-1 (slowest), r_c from 0 to r-1, and t_c from 0 to t-1 (fastest). Each outer combination replays the L beats.
  - After the last outer combination, base += L and the outer counters reset to 0.
- EMIT:
  - out_valid=1.
  - A transfer happens when out_valid && out_ready. Without a transfer, all outputs hold stable.
  - On a transfer the position advances. On a burst-pass end it rewinds to base, or moves to base+L, in the same cycle (zero bubble).
- Markers:
  - out_burst_last=1 on beat L-1 of every pass.
  - out_last=1 on the final beat of the final pass of the final burst.
  - A transfer with out_last -> go to DONE.
- DONE: done=1 for one cycle, out_valid=0, then IDLE.
- busy: 1 in EMIT and DONE.
- Total beats = R*r*t*N. Every tuple is emitted exactly once per outer combination. No beats beyond N per pass.
- Index outputs:
  - Combinational from the counters.
  - Multiply results are truncated to the output widths; configs are legal when they fit.
  - Outputs read 0 in IDLE.
- abort: in any state -> next cycle IDLE, counters 0, no done pulse.
- Priority: reset > abort > start.

Decomposition:
- Shared package fisq_pkg:
  - state enum {IDLE, EMIT, DONE};
  - packed cfg struct (R, S, p, q, r, t, burst_len);
  - clamp-to-1 helper function.
- One sub-module, nested_wrap_counter:
  - parametrised 3-digit mixed-radix counter with inc, load, wrap-out and snapshot/restore of a base value;
  - instantiated once for the inner (p, q, S) digits and once for the outer (t, r, R) digits.

Test Plan:
1. Basic bursts: p=2, q=1, S=3, burst_len=4, t=2, r=1, R=1, out_ready=1 -> exactly 12 beats.
   - (filter_index, col_index) sequence: (0,0)(1,0)(0,1)(1,1) | (2,0)(3,0)(2,1)(3,1) | (0,2)(1,2) | (2,2)(3,2).
   - out_burst_last on beats 3, 7, 9, 11; out_last on beat 11; done pulses the next cycle.
2. Backpressure: same config, out_ready toggled 1,0,0,1,... -> outputs stable while stalled; identical 12-beat sequence; no drops or duplicates.
3. Full outer nest: p=1, q=2, S=1, burst_len=2, t=1, r=2, R=2.
   - 4 beats with channel_index 0,1,2,3 (r_c=0, then r_c=1) at row 0, then 0,1,2,3 at row 1.
   - out_last on beat 7.
4. Corner configs: burst_len=0 (clamped to 1) with N=3, t=r=R=1 -> 3 beats, out_burst_last on each beat. burst_len=15 > N=3 -> single burst of 3.
5. Abort mid-sequence: assert abort at beat 5 -> next cycle out_valid=0, busy=0, no done. A subsequent start replays from index 0.
6. Control corners:
   - start during EMIT is ignored.
   - reset asserted with out_valid=1 -> all outputs 0 in the next cycle.
   - start and abort together in IDLE -> stays IDLE.
